// File: rtl/bus_oe_arbiter.sv
// Round-robin arbiter for four tri-state driver banks: registered one-hot grant,
// active-low output enables, bounded hold time and an all-off turnaround gap.
module bus_oe_arbiter #(
  parameter int HOLD_MAX   = 8,
  parameter int TURNAROUND = 1
) (
  input  logic       clk,
  input  logic       reset_bar,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [3:0] oe_bar,
  output logic [1:0] owner,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [7:0] r_hold;
  logic [7:0] w_hold_next;
  logic [3:0] r_turn;
  logic [3:0] w_turn_next;
  logic [1:0] r_last;
  logic [1:0] w_last_next;
  logic [1:0] r_owner;
  logic [1:0] w_owner_next;
  logic [3:0] r_gnt;
  logic [3:0] w_gnt_next;
  logic [3:0] r_oe_bar;
  logic       r_busy;

  logic [1:0] w_winner;
  logic [1:0] w_idx;
  logic       w_any_req;
  logic       w_release;

  // Scan from the farthest candidate back to last+1 so the nearest one wins.
  always_comb begin
    w_any_req = |req;
    w_winner  = r_last;
    w_idx     = r_last;
    for (int k = 4; k >= 1; k--) begin
      w_idx = r_last + 2'(k);
      if (req[w_idx]) begin
        w_winner = w_idx;
      end
    end
  end

  assign w_release = !req[r_owner] || (r_hold == 8'(HOLD_MAX));

  always_comb begin
    w_state_next = r_state;
    w_hold_next  = r_hold;
    w_turn_next  = r_turn;
    w_last_next  = r_last;
    w_owner_next = r_owner;
    w_gnt_next   = r_gnt;
    case (r_state)
      IDLE: begin
        w_gnt_next = 4'b0000;
        if (w_any_req) begin
          w_state_next = GRANT;
          w_gnt_next   = 4'b0001 << w_winner;
          w_owner_next = w_winner;
          w_hold_next  = 8'd1;
        end
      end
      GRANT: begin
        if (w_release) begin
          w_state_next = TURN;
          w_gnt_next   = 4'b0000;
          w_last_next  = r_owner;
          w_turn_next  = 4'd1;
        end else begin
          w_hold_next = r_hold + 8'd1;
        end
      end
      TURN: begin
        w_gnt_next = 4'b0000;
        if (r_turn == 4'(TURNAROUND)) begin
          w_state_next = IDLE;
          w_turn_next  = 4'd0;
        end else begin
          w_turn_next = r_turn + 4'd1;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_gnt_next   = 4'b0000;
      end
    endcase
  end

  // Enables are registered from the same next-grant value, so they can never
  // disagree with gnt and are forced off the instant reset asserts.
  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      r_state  <= IDLE;
      r_hold   <= 8'd0;
      r_turn   <= 4'd0;
      r_last   <= 2'd3;
      r_owner  <= 2'd0;
      r_gnt    <= 4'b0000;
      r_oe_bar <= 4'b1111;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_hold   <= w_hold_next;
      r_turn   <= w_turn_next;
      r_last   <= w_last_next;
      r_owner  <= w_owner_next;
      r_gnt    <= w_gnt_next;
      r_oe_bar <= ~w_gnt_next;
      r_busy   <= (w_state_next != IDLE);
    end
  end

  assign gnt    = r_gnt;
  assign oe_bar = r_oe_bar;
  assign owner  = r_owner;
  assign busy   = r_busy;

endmodule

// File: tb/tb_bus_oe_arbiter.sv
// Bench for bus_oe_arbiter: three parameter sets run side by side against a
// grant/gap model, plus literal expectations for the directed scenarios.
module tb_bus_oe_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_bar;
  logic [3:0] req_a  [3];
  logic [3:0] gnt_a  [3];
  logic [3:0] oe_a   [3];
  logic [1:0] own_a  [3];
  logic       busy_a [3];

  int tests = 0;
  int fails = 0;

  bus_oe_arbiter u_dut0 (
    .clk(clk), .reset_bar(reset_bar), .req(req_a[0]),
    .gnt(gnt_a[0]), .oe_bar(oe_a[0]), .owner(own_a[0]), .busy(busy_a[0])
  );

  bus_oe_arbiter #(.HOLD_MAX(4)) u_dut1 (
    .clk(clk), .reset_bar(reset_bar), .req(req_a[1]),
    .gnt(gnt_a[1]), .oe_bar(oe_a[1]), .owner(own_a[1]), .busy(busy_a[1])
  );

  bus_oe_arbiter #(.TURNAROUND(3)) u_dut2 (
    .clk(clk), .reset_bar(reset_bar), .req(req_a[2]),
    .gnt(gnt_a[2]), .oe_bar(oe_a[2]), .owner(own_a[2]), .busy(busy_a[2])
  );

  // Model: who holds the bus, for how long, and how many edges since release.
  int hm  [3] = '{8, 4, 8};
  int ta  [3] = '{1, 1, 3};
  int m_cur   [3];
  int m_glen  [3];
  int m_since [3];
  int m_last  [3];
  int m_own   [3];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset(input int i);
    m_cur[i]   = -1;
    m_glen[i]  = 0;
    m_since[i] = ta[i];
    m_last[i]  = 3;
    m_own[i]   = 0;
  endtask

  task automatic model_edge(input int i);
    logic [3:0] r;
    int idx;
    r = req_a[i];
    if (m_cur[i] >= 0) begin
      if (!r[m_cur[i]] || m_glen[i] == hm[i]) begin
        m_last[i]  = m_cur[i];
        m_cur[i]   = -1;
        m_since[i] = 0;
      end else begin
        m_glen[i]++;
      end
    end else begin
      if (m_since[i] < 1000) m_since[i]++;
      if (m_since[i] >= ta[i] + 1 && r != 4'b0000) begin
        for (int k = 1; k <= 4; k++) begin
          idx = (m_last[i] + k) % 4;
          if (r[idx] && m_cur[i] < 0) m_cur[i] = idx;
        end
        m_own[i]  = m_cur[i];
        m_glen[i] = 1;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) model_reset(i);
    forever begin
      @(posedge clk or negedge reset_bar);
      for (int i = 0; i < 3; i++) begin
        if (!reset_bar) model_reset(i);
        else model_edge(i);
      end
    end
  end

  initial begin
    logic [3:0] eg;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        eg = (m_cur[i] >= 0) ? (4'b0001 << m_cur[i]) : 4'b0000;
        check($sformatf("model_gnt%0d", i), {4'b0, gnt_a[i]}, {4'b0, eg});
        check($sformatf("model_oe%0d", i), {4'b0, oe_a[i]}, {4'b0, ~eg});
        check($sformatf("model_owner%0d", i), {6'b0, own_a[i]}, 8'(m_own[i]));
        check($sformatf("model_busy%0d", i), {7'b0, busy_a[i]},
              {7'b0, (m_cur[i] >= 0) || (m_since[i] < ta[i])});
      end
    end
  end

  task automatic tick;
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] e;
    reset_bar = 1'b0;
    for (int i = 0; i < 3; i++) req_a[i] = 4'b0000;
    repeat (3) tick();
    check("rst_gnt", {4'b0, gnt_a[0]}, 8'h00);
    check("rst_oe", {4'b0, oe_a[0]}, 8'h0f);
    check("rst_owner", {6'b0, own_a[0]}, 8'h00);
    check("rst_busy", {7'b0, busy_a[0]}, 8'h00);

    // All three instances run their own directed pattern concurrently.
    reset_bar = 1'b1;
    req_a[0] = 4'b1111;
    req_a[1] = 4'b0010;
    req_a[2] = 4'b0001;
    for (int p = 1; p <= 45; p++) begin
      tick();
      if (p % 10 == 1) begin
        e = 4'b0001 << ((p / 10) % 4);
        check($sformatf("rot_gnt_p%0d", p), {4'b0, gnt_a[0]}, {4'b0, e});
        check($sformatf("rot_owner_p%0d", p), {6'b0, own_a[0]}, 8'((p / 10) % 4));
      end
      if (p % 10 == 9 || p % 10 == 0) begin
        check($sformatf("rot_gap_p%0d", p), {4'b0, gnt_a[0]}, 8'h00);
      end
      e = (p % 6 >= 1 && p % 6 <= 4) ? 4'b0010 : 4'b0000;
      check($sformatf("hold4_gnt_p%0d", p), {4'b0, gnt_a[1]}, {4'b0, e});
      if (p <= 5) check($sformatf("ta3_hold_p%0d", p), {4'b0, gnt_a[2]}, 8'h01);
      if (p >= 6 && p <= 9) check($sformatf("ta3_off_p%0d", p), {4'b0, oe_a[2]}, 8'h0f);
      if (p == 10) begin
        check("ta3_gnt", {4'b0, gnt_a[2]}, 8'h04);
        check("ta3_owner", {6'b0, own_a[2]}, 8'h02);
      end
      if (p == 3) req_a[2] = 4'b0101;
      if (p == 5) req_a[2] = 4'b0100;
    end

    for (int i = 0; i < 3; i++) req_a[i] = 4'b0000;
    repeat (4) tick();

    req_a[0] = 4'b0100;
    tick();
    check("single_gnt", {4'b0, gnt_a[0]}, 8'h04);
    check("single_oe", {4'b0, oe_a[0]}, 8'h0b);
    check("single_owner", {6'b0, own_a[0]}, 8'h02);
    check("single_busy", {7'b0, busy_a[0]}, 8'h01);
    tick();
    tick();
    req_a[0] = 4'b0000;
    tick();
    check("single_turn_gnt", {4'b0, gnt_a[0]}, 8'h00);
    check("single_turn_busy", {7'b0, busy_a[0]}, 8'h01);
    check("single_turn_owner", {6'b0, own_a[0]}, 8'h02);
    tick();
    check("single_idle_busy", {7'b0, busy_a[0]}, 8'h00);
    check("single_idle_owner", {6'b0, own_a[0]}, 8'h02);

    req_a[0] = 4'b0001;
    tick();
    check("nopre_first", {4'b0, gnt_a[0]}, 8'h01);
    req_a[0] = 4'b1001;
    repeat (3) tick();
    check("nopre_hold", {4'b0, gnt_a[0]}, 8'h01);
    req_a[0] = 4'b1000;
    tick();
    check("nopre_turn", {4'b0, gnt_a[0]}, 8'h00);
    tick();
    check("nopre_idle", {4'b0, oe_a[0]}, 8'h0f);
    tick();
    check("nopre_win3", {4'b0, gnt_a[0]}, 8'h08);
    check("nopre_owner3", {6'b0, own_a[0]}, 8'h03);

    #2 reset_bar = 1'b0;
    #1;
    check("async_oe", {4'b0, oe_a[0]}, 8'h0f);
    check("async_gnt", {4'b0, gnt_a[0]}, 8'h00);
    check("async_busy", {7'b0, busy_a[0]}, 8'h00);
    tick();
    reset_bar = 1'b1;
    req_a[0] = 4'b1010;
    tick();
    check("post_rst_gnt", {4'b0, gnt_a[0]}, 8'h02);
    check("post_rst_owner", {6'b0, own_a[0]}, 8'h01);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bus_oe_arbiter.md
BUS_OE_ARBITER -- requirements
Module: bus_oe_arbiter

Interface
REQ-001 Parameter HOLD_MAX, default 8, maximum consecutive cycles one requester holds the bus (legal 1..255).
REQ-002 Parameter TURNAROUND, default 1, all-drivers-off cycles after each release (legal 1..15).
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  rising-edge system clock.
REQ-005 reset_bar  input  1  asynchronous active-low reset.
REQ-006 req  input  4  active-high bus requests, one per tri-state driver bank.
REQ-007 gnt  output  4  active-high one-hot grant; all zero when no owner.
REQ-008 oe_bar  output  4  active-low output enables for tri-state buffer banks, always the bitwise inverse of gnt.
REQ-009 owner  output  2  index of the current or most recent grantee.
REQ-010 busy  output  1  high while in GRANT or TURN.

Function
REQ-011 All outputs SHALL be registered; there SHALL be no combinational path from req to gnt or oe_bar.
REQ-012 At most one gnt bit SHALL be high in any cycle; oe_bar SHALL never have more than one bit low.
REQ-013 The FSM SHALL have three states: IDLE, GRANT, TURN.
REQ-014 IDLE: if any req bit is high at a rising edge, the FSM SHALL enter GRANT on that edge with gnt set to the winner; otherwise it SHALL remain in IDLE with gnt=0.
REQ-015 Winner selection SHALL be round-robin: search from (last+1) mod 4 upward with wrap, where last is the previous grantee.
REQ-016 Grant latency SHALL be one clock: req sampled at edge N gives gnt visible after edge N.
REQ-017 GRANT: a hold counter SHALL load 1 on entry and increment each further cycle in GRANT.
REQ-018 GRANT: the FSM SHALL go to TURN when req[owner] is low at an edge, or when the counter equals HOLD_MAX at an edge; gnt SHALL clear on that same edge.
REQ-019 If both release conditions are true at the same edge, the FSM SHALL go to TURN once, with identical behaviour.
REQ-020 Requests from non-owners during GRANT SHALL be ignored until arbitration in IDLE; they SHALL NOT preempt the owner.
REQ-021 TURN: gnt SHALL be 0 for exactly TURNAROUND cycles, then the FSM SHALL enter IDLE.
REQ-022 Minimum all-off gap between successive grants SHALL be TURNAROUND+1 cycles: TURNAROUND in TURN plus one arbitration cycle in IDLE.
REQ-023 On entry to TURN, last SHALL be updated to owner, so a forced-release requester re-wins only when no other req is high.
REQ-024 owner SHALL update only on entry to GRANT and SHALL hold its value through TURN and IDLE.
REQ-025 A req pulse shorter than one cycle that is not high at an edge SHALL be ignored.
REQ-026 A requester whose req drops and rises again within GRANT SHALL lose the grant at the first edge where req is sampled low.

Reset
REQ-027 While reset_bar is low: state=IDLE, gnt=0, oe_bar=4'b1111, owner=0, busy=0, hold counter=0, last=3, so req[0] has first priority.
REQ-028 Reset assertion mid-GRANT or mid-TURN SHALL force oe_bar to 4'b1111 immediately, without waiting for clk.
REQ-029 After reset_bar rises, the first arbitration SHALL occur at the first rising edge with reset_bar high.

Verification
REQ-030 Reset, then req=4'b0100 held for 3 cycles then dropped -> gnt=4'b0100 and oe_bar=4'b1011 one edge after req, for 3 cycles; then 1 cycle all-off (TURN) and IDLE; owner=2.
REQ-031 req=4'b1111 held continuously, default parameters -> grants rotate 0,1,2,3,0, each 8 cycles long, separated by 2 all-off cycles; gnt never has two bits high.
REQ-032 req[1] held alone, HOLD_MAX=4 -> gnt=4'b0010 for 4 cycles, 2 off cycles, then regranted to 1; repeats.
REQ-033 Owner 0 holding, req[3] rises mid-grant -> no preemption; req[3] wins at the next IDLE after req[0] drops.
REQ-034 TURNAROUND=3, owner drops req while req[2] is pending -> exactly 3 TURN cycles plus 1 IDLE cycle with oe_bar=4'b1111 before gnt=4'b0100.
REQ-035 reset_bar pulsed low asynchronously mid-GRANT -> oe_bar=4'b1111 before the next clk edge; after release, req=4'b1010 -> gnt=4'b0010.
